// File: rtl/l2_access_sequencer.sv
// Round-robin sequencer sharing one L2 tag lookup/fill port between N_REQ
// requesters; models hit/miss service delay and returns one response per grant.
module l2_access_sequencer #(
  parameter int N_REQ      = 4,
  parameter int REQ_ID_W   = 2,
  parameter int ADDR_W     = 32,
  parameter int L2_DELAY   = 20,
  parameter int DRAM_DELAY = 400,
  parameter int CNT_W      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_grant,
  output logic [ADDR_W-1:0]       tag_lookup_addr,
  input  logic                    tag_hit,
  output logic                    tag_write,
  output logic [ADDR_W-1:0]       tag_write_addr,
  output logic                    resp_valid,
  output logic [REQ_ID_W-1:0]     resp_id,
  output logic [ADDR_W-1:0]       resp_addr,
  output logic                    resp_hit,
  output logic                    busy,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    HIT_WAIT  = 3'd2,
    MISS_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t              state_q;
  logic [REQ_ID_W-1:0] rr_ptr_q;
  logic [REQ_ID_W-1:0] id_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                hit_q;

  logic [REQ_ID_W-1:0] win_id;
  logic [REQ_ID_W-1:0] cand;
  logic                win_found;
  logic                active;
  logic                grant_go;

  // Search starts one past the last winner; index arithmetic wraps since N_REQ is a power of 2.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = rr_ptr_q + REQ_ID_W'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign active   = !reset && !stall;
  assign grant_go = active && (state_q == IDLE) && win_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= REQ_ID_W'(N_REQ - 1);
      cnt_q    <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      hit_q    <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            addr_q   <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            id_q     <= win_id;
            rr_ptr_q <= win_id;
            state_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= tag_hit;
          if (tag_hit) begin
            cnt_q   <= CNT_W'(L2_DELAY - 1);
            state_q <= HIT_WAIT;
          end else begin
            cnt_q   <= CNT_W'(DRAM_DELAY - 1);
            state_q <= MISS_WAIT;
          end
        end
        HIT_WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        MISS_WAIT: begin
          if (cnt_q == '0) state_q <= FILL;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        FILL:    state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pulses are decoded from the held state, so a stalled pulse simply fires on the first free cycle.
  assign req_grant       = grant_go ? (N_REQ'(1) << win_id) : '0;
  assign tag_lookup_addr = (!reset && state_q == LOOKUP) ? addr_q : '0;
  assign tag_write       = active && (state_q == FILL);
  assign tag_write_addr  = tag_write ? addr_q : '0;
  assign resp_valid      = active && (state_q == RESP);
  assign resp_id         = resp_valid ? id_q : '0;
  assign resp_addr       = resp_valid ? addr_q : '0;
  assign resp_hit        = resp_valid && hit_q;
  assign busy            = !reset && (state_q != IDLE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_l2_access_sequencer.sv
// Bench for l2_access_sequencer: directed scenarios on a default-delay instance
// and randomized traffic with stalls on a minimum-delay instance.
module tb_l2_access_sequencer;

  localparam int L2 = 20;
  localparam int DR = 400;
  localparam int M_L2 = 1;
  localparam int M_DR = 1;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_last;
  int   m_last;

  logic reset, stall, tag_hit;
  logic [3:0] req_valid, req_grant;
  logic [127:0] req_addr;
  logic [31:0] tag_lookup_addr, tag_write_addr, resp_addr;
  logic tag_write, resp_valid, resp_hit, busy;
  logic [1:0] resp_id;
  logic [2:0] dbg_state;

  logic m_reset, m_stall, m_tag_hit;
  logic [3:0] m_req_valid, m_req_grant;
  logic [127:0] m_req_addr;
  logic [31:0] m_tag_lookup_addr, m_tag_write_addr, m_resp_addr;
  logic m_tag_write, m_resp_valid, m_resp_hit, m_busy;
  logic [1:0] m_resp_id;
  logic [2:0] m_dbg_state;

  l2_access_sequencer #(.N_REQ(4), .REQ_ID_W(2), .ADDR_W(32), .L2_DELAY(L2),
                        .DRAM_DELAY(DR), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid), .req_addr(req_addr),
    .req_grant(req_grant), .tag_lookup_addr(tag_lookup_addr), .tag_hit(tag_hit),
    .tag_write(tag_write), .tag_write_addr(tag_write_addr), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_addr(resp_addr), .resp_hit(resp_hit), .busy(busy),
    .dbg_state_o(dbg_state));

  l2_access_sequencer #(.N_REQ(4), .REQ_ID_W(2), .ADDR_W(32), .L2_DELAY(M_L2),
                        .DRAM_DELAY(M_DR), .CNT_W(10)) dut_min (
    .clk(clk), .reset(m_reset), .stall(m_stall), .req_valid(m_req_valid), .req_addr(m_req_addr),
    .req_grant(m_req_grant), .tag_lookup_addr(m_tag_lookup_addr), .tag_hit(m_tag_hit),
    .tag_write(m_tag_write), .tag_write_addr(m_tag_write_addr), .resp_valid(m_resp_valid),
    .resp_id(m_resp_id), .resp_addr(m_resp_addr), .resp_hit(m_resp_hit), .busy(m_busy),
    .dbg_state_o(m_dbg_state));

  // Clock and cycle index (inputs change 1ns after posedge, outputs sampled at negedge)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int next_winner(input logic [3:0] mask, input int last);
    for (int k = 1; k <= 4; k++) if (mask[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; m_reset = 1'b1; stall = 1'b0; m_stall = 1'b0;
    req_valid = '0; m_req_valid = '0; req_addr = '0; m_req_addr = '0;
    tag_hit = 1'b0; m_tag_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; m_reset = 1'b0;
    model_last = 3; m_last = 3;
  endtask

  task automatic wait_grant(input int max, output int t, output logic [3:0] g);
    t = -1; g = '0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (req_grant != 0) begin t = cyc; g = req_grant; break; end
    end
  endtask

  task automatic wait_resp(input int max, output int t_resp, output int t_wr,
                           output logic [31:0] wr_addr, output int n_wr, output logic [31:0] lk,
                           output logic [1:0] id, output logic [31:0] addr, output logic hit);
    t_resp = -1; t_wr = -1; wr_addr = '0; n_wr = 0; lk = '0; id = '0; addr = '0; hit = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (tag_lookup_addr != 0 && lk == 0) lk = tag_lookup_addr;
      if (tag_write) begin n_wr++; t_wr = cyc; wr_addr = tag_write_addr; end
      if (resp_valid) begin t_resp = cyc; id = resp_id; addr = resp_addr; hit = resp_hit; break; end
    end
  endtask

  // Runs cycles after a grant with stall high for offsets [s0, s0+slen); counts response pulses.
  task automatic run_stall(input int s0, input int slen, input int span,
                           output int n_resp, output int t_resp);
    n_resp = 0; t_resp = -1;
    for (int k = 1; k <= span; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = '0;
      stall = (k >= s0 && k < s0 + slen);
      @(negedge clk);
      if (resp_valid) begin n_resp++; t_resp = k; end
    end
    stall = 1'b0;
  endtask

  // One transaction on the minimum-delay instance; times are counted in non-stalled cycles after the grant.
  task automatic m_txn(input logic [3:0] mask, input logic [127:0] addrs, input logic hit,
                       input int pct, output logic [3:0] g, output int ns_wr, output int n_wr,
                       output logic [31:0] wr_addr, output logic [31:0] lk, output int ns_resp,
                       output logic [1:0] id, output logic [31:0] addr, output logic rhit);
    int ns;
    g = '0; ns_wr = -1; n_wr = 0; wr_addr = '0; lk = '0; ns_resp = -1; id = '0; addr = '0; rhit = 1'b0;
    @(posedge clk); #1;
    m_req_valid = mask; m_req_addr = addrs; m_tag_hit = hit;
    m_stall = ($urandom_range(99, 0) < pct);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_req_grant != 0) begin g = m_req_grant; break; end
      @(posedge clk); #1;
      m_stall = ($urandom_range(99, 0) < pct);
    end
    ns = 0;
    if (g != 0) begin
      for (int k = 0; k < 60; k++) begin
        @(posedge clk); #1;
        if (k == 0) m_req_valid = '0;
        m_stall = ($urandom_range(99, 0) < pct);
        @(negedge clk);
        if (!m_stall) ns++;
        if (m_tag_lookup_addr != 0 && lk == 0) lk = m_tag_lookup_addr;
        if (m_tag_write) begin n_wr++; ns_wr = ns; wr_addr = m_tag_write_addr; end
        if (m_resp_valid) begin ns_resp = ns; id = m_resp_id; addr = m_resp_addr; rhit = m_resp_hit; break; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m_reset = 1'b1; stall = 1'b0; m_stall = 1'b0;
    req_valid = 4'hF; m_req_valid = 4'hF; req_addr = {4{32'h1234}}; m_req_addr = '0;
    tag_hit = 1'b0; m_tag_hit = 1'b0;
    @(negedge clk);
    checks++; if (req_grant !== 4'b0) begin errors++; $display("FAIL reset_grant_in_reset: got %b expected 0000", req_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_in_reset: got %b expected 0", busy); end
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy, m_busy); end
    checks++; if (resp_valid !== 1'b0 || tag_write !== 1'b0) begin errors++; $display("FAIL reset_pulses: got resp %b write %b expected 0 0", resp_valid, tag_write); end
    checks++; if (tag_lookup_addr !== 32'h0 || resp_addr !== 32'h0) begin errors++; $display("FAIL reset_addrs: got lookup %h resp %h expected 0 0", tag_lookup_addr, resp_addr); end
    checks++; if (busy !== (dbg_state != 3'd0)) begin errors++; $display("FAIL reset_state_busy: got busy %b state %0d expected consistent", busy, dbg_state); end
  endtask

  task automatic test_hit();
    int t, tr, tw, nw; logic [3:0] g; logic [31:0] wa, lk, ra; logic [1:0] id; logic h;
    @(posedge clk); #1;
    req_valid = 4'b0001; req_addr = '0; req_addr[31:0] = 32'h1000; tag_hit = 1'b1;
    wait_grant(10, t, g);
    @(posedge clk); #1 req_valid = '0;
    wait_resp(40, tr, tw, wa, nw, lk, id, ra, h);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL hit_grant: got %b expected 0001", g); end
    checks++; if (lk !== 32'h1000) begin errors++; $display("FAIL hit_lookup_addr: got %h expected 00001000", lk); end
    checks++; if (tr !== t + L2 + 2) begin errors++; $display("FAIL hit_latency: got %0d expected %0d", tr - t, L2 + 2); end
    checks++; if (id !== 2'd0 || h !== 1'b1 || ra !== 32'h1000) begin errors++; $display("FAIL hit_resp: got id %0d hit %b addr %h expected 0 1 00001000", id, h, ra); end
    checks++; if (nw !== 0) begin errors++; $display("FAIL hit_no_write: got %0d writes expected 0", nw); end
    model_last = 0;
  endtask

  task automatic test_miss_reuse();
    int t, tr, tw, nw; logic [3:0] g; logic [31:0] wa, lk, ra; logic [1:0] id; logic h;
    @(posedge clk); #1;
    req_valid = 4'b0001; req_addr[31:0] = 32'h2040; tag_hit = 1'b0;
    wait_grant(10, t, g);
    @(posedge clk); #1 req_valid = '0;
    wait_resp(DR + 20, tr, tw, wa, nw, lk, id, ra, h);
    checks++; if (tw !== t + DR + 2 || wa !== 32'h2040 || nw !== 1) begin errors++; $display("FAIL miss_write: got at +%0d addr %h count %0d expected +%0d 00002040 1", tw - t, wa, nw, DR + 2); end
    checks++; if (tr !== t + DR + 3 || h !== 1'b0 || ra !== 32'h2040) begin errors++; $display("FAIL miss_resp: got at +%0d hit %b addr %h expected +%0d 0 00002040", tr - t, h, ra, DR + 3); end
    @(posedge clk); #1;
    req_valid = 4'b0001; tag_hit = 1'b1;
    wait_grant(10, t, g);
    @(posedge clk); #1 req_valid = '0;
    wait_resp(40, tr, tw, wa, nw, lk, id, ra, h);
    checks++; if (h !== 1'b1 || tr !== t + L2 + 2 || nw !== 0) begin errors++; $display("FAIL reuse_hit: got hit %b at +%0d writes %0d expected 1 +%0d 0", h, tr - t, nw, L2 + 2); end
  endtask

  task automatic test_round_robin();
    int t, prev, exp_w, tr, tw, nw; logic [3:0] g; logic [31:0] wa, lk, ra; logic [1:0] id; logic h;
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'hF; req_addr = {32'h4300, 32'h4200, 32'h4100, 32'h4000}; tag_hit = 1'b1;
    prev = 0; exp_w = 0;
    for (int i = 0; i < 5; i++) begin
      exp_w = next_winner(4'hF, model_last);
      wait_grant(40, t, g);
      checks++; if (g !== 4'(1 << exp_w)) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, g, 4'(1 << exp_w)); end
      if (i > 0) begin
        checks++; if (t - prev !== L2 + 3) begin errors++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", i, t - prev, L2 + 3); end
      end
      model_last = exp_w; prev = t;
    end
    @(posedge clk); #1 req_valid = '0;
    wait_resp(40, tr, tw, wa, nw, lk, id, ra, h);
    checks++; if (int'(id) !== exp_w || ra !== 32'h4000 + 32'(exp_w) * 32'h100) begin errors++; $display("FAIL rr_last_resp: got id %0d addr %h expected %0d", id, ra, exp_w); end
  endtask

  task automatic test_stall();
    int t, n, tr; logic [3:0] g;
    @(posedge clk); #1;
    req_valid = 4'b0100; req_addr[95:64] = 32'h3000; tag_hit = 1'b1;
    wait_grant(10, t, g);
    run_stall(5, 5, 40, n, tr);
    checks++; if (n !== 1 || tr !== L2 + 7) begin errors++; $display("FAIL stall_wait: got %0d pulses at +%0d expected 1 at +%0d", n, tr, L2 + 7); end
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_grant(10, t, g);
    run_stall(L2 + 2, 3, 40, n, tr);
    checks++; if (n !== 1 || tr !== L2 + 5) begin errors++; $display("FAIL stall_resp: got %0d pulses at +%0d expected 1 at +%0d", n, tr, L2 + 5); end
    model_last = 2;
  endtask

  task automatic test_reset_mid_miss();
    int t, nw, nr, tr, tw, nw2; logic [3:0] g; logic [31:0] wa, lk, ra; logic [1:0] id; logic h;
    @(posedge clk); #1;
    req_valid = 4'b1000; req_addr[127:96] = 32'h5000; tag_hit = 1'b0;
    wait_grant(10, t, g);
    @(posedge clk); #1 req_valid = '0;
    repeat (49) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midmiss_busy: got %b expected 1", busy); end
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midmiss_busy_after_reset: got %b expected 0", busy); end
    nw = 0; nr = 0;
    for (int k = 0; k < DR + 50; k++) begin
      @(negedge clk);
      if (tag_write) nw++;
      if (resp_valid) nr++;
    end
    checks++; if (nw !== 0 || nr !== 0) begin errors++; $display("FAIL midmiss_dropped: got writes %0d resps %0d expected 0 0", nw, nr); end
    model_last = 3;
    @(posedge clk); #1 req_valid = 4'hF; tag_hit = 1'b1;
    wait_grant(10, t, g);
    checks++; if (g !== 4'(1 << next_winner(4'hF, model_last))) begin errors++; $display("FAIL midmiss_next_grant: got %b expected 0001", g); end
    @(posedge clk); #1 req_valid = '0;
    wait_resp(40, tr, tw, wa, nw2, lk, id, ra, h);
  endtask

  task automatic test_min_delays();
    logic [3:0] g; int ns_wr, n_wr, ns_resp; logic [31:0] wa, lk, ra; logic [1:0] id; logic rh;
    m_txn(4'b0010, {32'h0, 32'h0, 32'h6000, 32'h0}, 1'b1, 0, g, ns_wr, n_wr, wa, lk, ns_resp, id, ra, rh);
    checks++; if (g !== 4'b0010 || ns_resp !== M_L2 + 2 || n_wr !== 0 || rh !== 1'b1) begin errors++; $display("FAIL min_hit: got grant %b resp +%0d writes %0d hit %b expected 0010 +%0d 0 1", g, ns_resp, n_wr, rh, M_L2 + 2); end
    m_txn(4'b0010, {32'h0, 32'h0, 32'h6040, 32'h0}, 1'b0, 0, g, ns_wr, n_wr, wa, lk, ns_resp, id, ra, rh);
    checks++; if (ns_wr !== M_DR + 2 || wa !== 32'h6040 || n_wr !== 1) begin errors++; $display("FAIL min_miss_write: got +%0d addr %h count %0d expected +%0d 00006040 1", ns_wr, wa, n_wr, M_DR + 2); end
    checks++; if (ns_resp !== M_DR + 3 || rh !== 1'b0 || id !== 2'd1) begin errors++; $display("FAIL min_miss_resp: got +%0d hit %b id %0d expected +%0d 0 1", ns_resp, rh, id, M_DR + 3); end
    m_last = 1;
  endtask

  task automatic test_random();
    logic [3:0] mask, g; logic [127:0] addrs; logic hit, rh; int w, ns_wr, n_wr, ns_resp;
    logic [31:0] wa, lk, ra, ea; logic [1:0] id;
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(15, 1));
      addrs = {$urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1};
      hit = 1'($urandom_range(1, 0));
      w = next_winner(mask, m_last);
      ea = addrs[w*32 +: 32];
      m_txn(mask, addrs, hit, 25, g, ns_wr, n_wr, wa, lk, ns_resp, id, ra, rh);
      checks++; if (g !== 4'(1 << w)) begin errors++; $display("FAIL rand_grant_%0d: got %b expected %b", i, g, 4'(1 << w)); end
      checks++; if (lk !== ea || int'(id) !== w || ra !== ea || rh !== hit) begin errors++; $display("FAIL rand_resp_%0d: got lk %h id %0d addr %h hit %b expected %h %0d %h %b", i, lk, id, ra, rh, ea, w, ea, hit); end
      if (hit) begin
        checks++; if (ns_resp !== M_L2 + 2 || n_wr !== 0) begin errors++; $display("FAIL rand_hit_timing_%0d: got +%0d writes %0d expected +%0d 0", i, ns_resp, n_wr, M_L2 + 2); end
      end else begin
        checks++; if (ns_wr !== M_DR + 2 || n_wr !== 1 || wa !== ea || ns_resp !== M_DR + 3) begin errors++; $display("FAIL rand_miss_timing_%0d: got wr +%0d n %0d addr %h resp +%0d expected +%0d 1 %h +%0d", i, ns_wr, n_wr, wa, ns_resp, M_DR + 2, ea, M_DR + 3); end
      end
      m_last = w;
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_reuse();
    test_round_robin();
    test_stall();
    test_reset_mid_miss();
    test_min_delays();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
